// File: rtl/score_sequencer_if.sv
// Point-request / scoreboard-drive bundle between game logic and score_sequencer.
interface score_sequencer_if;
  logic       p1_point;
  logic       p2_point;
  logic       new_game;
  logic       add1_p1;
  logic       add1_p2;
  logic       clear_score;
  logic [3:0] p1_tens;
  logic [3:0] p1_ones;
  logic [3:0] p2_tens;
  logic [3:0] p2_ones;
  logic       game_over;
  logic [1:0] winner;
  logic       drop;

  modport slave (
    input  p1_point, p2_point, new_game,
    output add1_p1, add1_p2, clear_score,
    output p1_tens, p1_ones, p2_tens, p2_ones,
    output game_over, winner, drop
  );

  modport master (
    output p1_point, p2_point, new_game,
    input  add1_p1, add1_p2, clear_score,
    input  p1_tens, p1_ones, p2_tens, p2_ones,
    input  game_over, winner, drop
  );
endinterface

// File: rtl/score_sequencer.sv
// Two-player match controller: queues point requests, issues spaced increment
// pulses to BCD scoreboards, mirrors the scores and sequences clear/restart.
//
// state | meaning
// ------+-------------------------------------------------------------
// CLEAR | clear_score high for two cycles, scores and queues held at 0
// IDLE  | waiting for a pending point; round-robin grant on ties
// PULSE | add1 of the granted player high for this cycle
// GAP   | add1 low; check granted player's mirror against WIN_SCORE
// OVER  | match won; requests ignored until new_game or reset
module score_sequencer #(
  parameter logic [7:0] WIN_SCORE = 8'h11
) (
  input  logic              clk,
  input  logic              reset,
  score_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_PULSE, S_GAP, S_OVER} state_t;

  state_t     state, state_nxt;
  logic       clr_cnt, clr_cnt_nxt;
  logic [1:0] pend1, pend1_nxt, pend2, pend2_nxt;
  logic       last_p2, last_p2_nxt;
  logic       cur_p2, cur_p2_nxt;
  logic [7:0] p1_bcd, p1_bcd_nxt, p2_bcd, p2_bcd_nxt;
  logic       add1_p1_r, add1_p1_nxt, add1_p2_r, add1_p2_nxt;
  logic       clear_r, clear_nxt;
  logic [1:0] winner_r, winner_nxt;
  logic       over_r, over_nxt;
  logic       drop_r, drop_nxt;
  logic       grant1, grant2;

  // Same wrap behaviour as the external scoreboard: 09 -> 10, 99 -> 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] < 4'd9)
      return {v[7:4], v[3:0] + 4'd1};
    else if (v[7:4] < 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return 8'h00;
  endfunction

  function automatic logic [1:0] pend_step(input logic [1:0] cnt, input logic req,
                                           input logic grant);
    if (req && !grant)
      return (cnt == 2'd3) ? cnt : cnt + 2'd1;
    else if (grant && !req)
      return cnt - 2'd1;
    else
      return cnt;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_CLEAR;
      clr_cnt   <= 1'b0;
      pend1     <= 2'd0;
      pend2     <= 2'd0;
      last_p2   <= 1'b1;
      cur_p2    <= 1'b0;
      p1_bcd    <= 8'h00;
      p2_bcd    <= 8'h00;
      add1_p1_r <= 1'b0;
      add1_p2_r <= 1'b0;
      clear_r   <= 1'b1;
      winner_r  <= 2'b00;
      over_r    <= 1'b0;
      drop_r    <= 1'b0;
    end else begin
      state     <= state_nxt;
      clr_cnt   <= clr_cnt_nxt;
      pend1     <= pend1_nxt;
      pend2     <= pend2_nxt;
      last_p2   <= last_p2_nxt;
      cur_p2    <= cur_p2_nxt;
      p1_bcd    <= p1_bcd_nxt;
      p2_bcd    <= p2_bcd_nxt;
      add1_p1_r <= add1_p1_nxt;
      add1_p2_r <= add1_p2_nxt;
      clear_r   <= clear_nxt;
      winner_r  <= winner_nxt;
      over_r    <= over_nxt;
      drop_r    <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    pend1_nxt   = pend1;
    pend2_nxt   = pend2;
    last_p2_nxt = last_p2;
    cur_p2_nxt  = cur_p2;
    p1_bcd_nxt  = p1_bcd;
    p2_bcd_nxt  = p2_bcd;
    add1_p1_nxt = 1'b0;
    add1_p2_nxt = 1'b0;
    clear_nxt   = 1'b0;
    winner_nxt  = winner_r;
    over_nxt    = over_r;
    drop_nxt    = 1'b0;
    grant1      = 1'b0;
    grant2      = 1'b0;

    case (state)
      S_CLEAR: begin
        pend1_nxt  = 2'd0;
        pend2_nxt  = 2'd0;
        p1_bcd_nxt = 8'h00;
        p2_bcd_nxt = 8'h00;
        winner_nxt = 2'b00;
        over_nxt   = 1'b0;
        if (clr_cnt) begin
          state_nxt   = S_IDLE;
          clr_cnt_nxt = 1'b0;
        end else begin
          clr_cnt_nxt = 1'b1;
          clear_nxt   = 1'b1;
        end
      end
      S_IDLE: begin
        grant1 = (pend1 != 2'd0) && ((pend2 == 2'd0) || last_p2);
        grant2 = (pend2 != 2'd0) && !grant1;
        if (grant1) begin
          state_nxt   = S_PULSE;
          add1_p1_nxt = 1'b1;
          p1_bcd_nxt  = bcd_inc(p1_bcd);
          last_p2_nxt = 1'b0;
          cur_p2_nxt  = 1'b0;
        end else if (grant2) begin
          state_nxt   = S_PULSE;
          add1_p2_nxt = 1'b1;
          p2_bcd_nxt  = bcd_inc(p2_bcd);
          last_p2_nxt = 1'b1;
          cur_p2_nxt  = 1'b1;
        end
      end
      S_PULSE: state_nxt = S_GAP;
      S_GAP: begin
        if ((cur_p2 ? p2_bcd : p1_bcd) == WIN_SCORE) begin
          state_nxt  = S_OVER;
          over_nxt   = 1'b1;
          winner_nxt = cur_p2 ? 2'b10 : 2'b01;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_OVER: begin
        pend1_nxt = 2'd0;
        pend2_nxt = 2'd0;
      end
      default: state_nxt = S_CLEAR;
    endcase

    if (state == S_IDLE || state == S_PULSE || state == S_GAP) begin
      pend1_nxt = pend_step(pend1, bus.p1_point, grant1);
      pend2_nxt = pend_step(pend2, bus.p2_point, grant2);
      drop_nxt  = (bus.p1_point && !grant1 && pend1 == 2'd3) ||
                  (bus.p2_point && !grant2 && pend2 == 2'd3);
    end

    // Restart wins over any grant or queued point in the same cycle.
    if (bus.new_game) begin
      state_nxt   = S_CLEAR;
      clr_cnt_nxt = 1'b0;
      clear_nxt   = 1'b1;
      pend1_nxt   = 2'd0;
      pend2_nxt   = 2'd0;
      p1_bcd_nxt  = 8'h00;
      p2_bcd_nxt  = 8'h00;
      winner_nxt  = 2'b00;
      over_nxt    = 1'b0;
      add1_p1_nxt = 1'b0;
      add1_p2_nxt = 1'b0;
      drop_nxt    = 1'b0;
    end
  end

  assign bus.add1_p1     = add1_p1_r;
  assign bus.add1_p2     = add1_p2_r;
  assign bus.clear_score = clear_r;
  assign bus.p1_tens     = p1_bcd[7:4];
  assign bus.p1_ones     = p1_bcd[3:0];
  assign bus.p2_tens     = p2_bcd[7:4];
  assign bus.p2_ones     = p2_bcd[3:0];
  assign bus.game_over   = over_r;
  assign bus.winner      = winner_r;
  assign bus.drop        = drop_r;

endmodule
